// File: rtl/ram_access_unit.sv
// Load/store initiator for a byte-enabled dual-port RAM with one-cycle registered reads.
// Accepts one request at a time, drives the RAM ports and returns a registered response.
module ram_access_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    localparam int WA = $clog2(DEPTH),
    localparam int AW = WA + 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               request_valid,
    output logic               request_ready,
    input  logic               request_write,
    input  logic [AW-1:0]      request_address,
    input  logic [1:0]         request_size,
    input  logic               request_signed,
    input  logic [WIDTH-1:0]   request_data,
    output logic               response_valid,
    input  logic               response_ready,
    output logic [WIDTH-1:0]   response_data,
    output logic               response_error,
    output logic [WA-1:0]      ram_read_address,
    input  logic [WIDTH-1:0]   ram_read_data,
    output logic [WA-1:0]      ram_write_address,
    output logic [WIDTH-1:0]   ram_write_data,
    output logic [WIDTH/8-1:0] ram_write_enable
);

    if (WIDTH != 32) begin : g_width_check
        $error("ram_access_unit supports WIDTH = 32 only");
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid, once raised, holds its payload stable until that edge.
    typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, RESPOND} state_t;

    state_t           state;
    logic [1:0]       lane_q;
    logic [1:0]       size_q;
    logic             signed_q;

    logic [1:0]         lane;
    logic [WA-1:0]      word;
    logic               misaligned;
    logic [WIDTH/8-1:0] mask;
    logic [WIDTH-1:0]   lane_data;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [WIDTH-1:0]   load_value;

    assign request_ready = (state == IDLE);
    assign lane          = request_address[1:0];
    assign word          = request_address[AW-1:2];
    assign misaligned    = (request_size == 2'd3) ||
                           (request_size == 2'd1 && lane[0]) ||
                           (request_size == 2'd2 && lane != 2'd0);

    always_comb begin
        mask      = 4'b1111;
        lane_data = request_data;
        case (request_size)
            2'd0: begin
                mask      = 4'b0001 << lane;
                lane_data = {4{request_data[7:0]}};
            end
            2'd1: begin
                mask      = 4'b0011 << lane;
                lane_data = {2{request_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection happens on the word the RAM returned for the address held in READ.
    assign byte_sel = ram_read_data[{lane_q, 3'b000} +: 8];
    assign half_sel = lane_q[1] ? ram_read_data[31:16] : ram_read_data[15:0];

    always_comb begin
        case (size_q)
            2'd0:    load_value = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'd1:    load_value = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_value = ram_read_data;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            lane_q            <= '0;
            size_q            <= '0;
            signed_q          <= 1'b0;
            response_valid    <= 1'b0;
            response_error    <= 1'b0;
            response_data     <= '0;
            ram_read_address  <= '0;
            ram_write_address <= '0;
            ram_write_data    <= '0;
            ram_write_enable  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request_valid) begin
                        lane_q   <= lane;
                        size_q   <= request_size;
                        signed_q <= request_signed;
                        if (misaligned) begin
                            response_error <= 1'b1;
                            response_data  <= '0;
                            response_valid <= 1'b1;
                            state          <= RESPOND;
                        end else if (request_write) begin
                            ram_write_address <= word;
                            ram_write_enable  <= mask;
                            ram_write_data    <= lane_data;
                            state             <= WRITE;
                        end else begin
                            ram_read_address <= word;
                            state            <= READ;
                        end
                    end
                end
                WRITE: begin
                    ram_write_enable <= '0;
                    response_data    <= '0;
                    response_error   <= 1'b0;
                    response_valid   <= 1'b1;
                    state            <= RESPOND;
                end
                READ: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    response_data  <= load_value;
                    response_error <= 1'b0;
                    response_valid <= 1'b1;
                    state          <= RESPOND;
                end
                RESPOND: begin
                    if (response_ready) begin
                        response_valid <= 1'b0;
                        response_error <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
